accumulator_alu: RTL and testbench

ACCUMULATOR_ALU -- requirements
Module: accumulator_alu

---
 rtl/accumulator_alu.sv | 144 ++++++++++++++
 tb/tb_accumulator_alu.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_alu.sv
// Accumulator ALU: one-cycle arithmetic/logic ops plus an optional shift-add multiplier.
// Define ACCUMULATOR_ALU_MUL_EN to build the multiplier; otherwise Op 111 is a NOP.
module accumulator_alu #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] B_in,
   output logic [WIDTH-1:0] Acc_out,
   output logic             Busy,
   output logic             Done,
   output logic             Zero,
   output logic             Carry
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
`ifdef ACCUMULATOR_ALU_MUL_EN
   localparam logic [1:0] MUL  = 2'd2;
   localparam int CNT_W = $clog2(WIDTH + 1);
`endif

   logic [1:0]       state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc;
   logic             zero;
   logic             carry;
   logic             done;

   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_write;

`ifdef ACCUMULATOR_ALU_MUL_EN
   // Product lives in {mul_hi, mul_lo}; mul_lo starts as the multiplier and
   // is shifted out one bit per cycle while the partial sum enters from the top.
   logic [WIDTH-1:0] mul_hi;
   logic [WIDTH-1:0] mul_lo;
   logic [CNT_W-1:0] mul_cnt;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_lo_next;

   always_comb begin
      mul_sum     = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, b_q} : '0);
      mul_lo_next = {mul_sum[0], mul_lo[WIDTH-1:1]};
   end
`endif

   always_comb begin
      alu_res   = acc;
      alu_carry = carry;
      alu_write = 1'b1;
      case (op_q)
         3'b000: begin alu_res = b_q;       alu_carry = 1'b0; end
         3'b001: {alu_carry, alu_res} = {1'b0, acc} + {1'b0, b_q};
         3'b010: begin
            alu_res   = acc - b_q;
            alu_carry = (b_q > acc);
         end
         3'b011: begin alu_res = acc & b_q; alu_carry = 1'b0; end
         3'b100: begin alu_res = acc | b_q; alu_carry = 1'b0; end
         3'b101: begin alu_res = acc ^ b_q; alu_carry = 1'b0; end
         3'b110: begin
            alu_res   = {acc[WIDTH-2:0], 1'b0};
            alu_carry = acc[WIDTH-1];
         end
         default: alu_write = 1'b0;
      endcase
   end

   // Done is a single-cycle pulse: cleared every edge unless an op completes.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state   <= IDLE;
         op_q    <= '0;
         b_q     <= '0;
         acc     <= '0;
         zero    <= 1'b1;
         carry   <= 1'b0;
         done    <= 1'b0;
`ifdef ACCUMULATOR_ALU_MUL_EN
         mul_hi  <= '0;
         mul_lo  <= '0;
         mul_cnt <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (Start) begin
                  op_q <= Op;
                  b_q  <= B_in;
`ifdef ACCUMULATOR_ALU_MUL_EN
                  if (Op == 3'b111) begin
                     state   <= MUL;
                     mul_hi  <= '0;
                     mul_lo  <= acc;
                     mul_cnt <= '0;
                  end else begin
                     state <= EXEC;
                  end
`else
                  state <= EXEC;
`endif
               end
            end
            EXEC: begin
               if (alu_write) begin
                  acc   <= alu_res;
                  carry <= alu_carry;
                  zero  <= (alu_res == '0);
               end
               done  <= 1'b1;
               state <= IDLE;
            end
`ifdef ACCUMULATOR_ALU_MUL_EN
            MUL: begin
               mul_hi  <= mul_sum[WIDTH:1];
               mul_lo  <= mul_lo_next;
               mul_cnt <= mul_cnt + 1'b1;
               if (mul_cnt == CNT_W'(WIDTH - 1)) begin
                  acc   <= mul_lo_next;
                  carry <= |mul_sum[WIDTH:1];
                  zero  <= (mul_lo_next == '0);
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign Acc_out = acc;
   assign Zero    = zero;
   assign Carry   = carry;
   assign Done    = done;
   assign Busy    = (state != IDLE);

endmodule

// File: tb/tb_accumulator_alu.sv
// Randomized scoreboard bench for accumulator_alu; expectations come from a plain-arithmetic model.
// Follows ACCUMULATOR_ALU_MUL_EN the same way the design does.
module tb_accumulator_alu;

   localparam int W = 8;

   logic         CLK = 1'b0;
   logic         Reset = 1'b0;
   logic         Start = 1'b0;
   logic [2:0]   Op = '0;
   logic [W-1:0] B_in = '0;
   logic [W-1:0] Acc_out;
   logic         Busy;
   logic         Done;
   logic         Zero;
   logic         Carry;

   typedef struct {
      logic [W-1:0] acc;
      logic         carry;
      int           edge_n;
   } exp_t;

   exp_t         exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           edge_cnt = 0;
   logic [W-1:0] m_acc = '0;
   logic         m_carry = 1'b0;

   accumulator_alu #(.WIDTH(W)) dut (
      .CLK    (CLK),
      .Reset  (Reset),
      .Start  (Start),
      .Op     (Op),
      .B_in   (B_in),
      .Acc_out(Acc_out),
      .Busy   (Busy),
      .Done   (Done),
      .Zero   (Zero),
      .Carry  (Carry)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   task automatic check_output(input string name, input longint actual, input longint expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, actual, expected, edge_cnt);
      end
   endtask

   // Issue one operation in IDLE and push the model's prediction of its completion.
   task automatic apply_stimulus(input logic [2:0] op, input logic [W-1:0] b);
      int guard = 0;
      int lat = 1;
      logic [2*W-1:0] prod;
      while (Busy && guard < 200) begin
         @(negedge CLK);
         guard++;
      end
      if (guard >= 200) begin
         total++;
         bad++;
         $display("[TB] FAIL busy_timeout: Busy stuck high");
      end
      Start = 1'b1;
      Op    = op;
      B_in  = b;
      case (op)
         3'd0: begin m_acc = b; m_carry = 1'b0; end
         3'd1: begin
            m_carry = ((int'(m_acc) + int'(b)) > (2**W - 1));
            m_acc   = W'((int'(m_acc) + int'(b)) % (2**W));
         end
         3'd2: begin
            m_carry = (b > m_acc);
            m_acc   = W'((int'(m_acc) - int'(b) + 2**W) % (2**W));
         end
         3'd3: begin m_acc = m_acc & b; m_carry = 1'b0; end
         3'd4: begin m_acc = m_acc | b; m_carry = 1'b0; end
         3'd5: begin m_acc = m_acc ^ b; m_carry = 1'b0; end
         3'd6: begin
            m_carry = (m_acc >= 2**(W-1));
            m_acc   = W'((int'(m_acc) * 2) % (2**W));
         end
         default: begin
`ifdef ACCUMULATOR_ALU_MUL_EN
            prod    = (2*W)'(int'(m_acc) * int'(b));
            m_acc   = W'(prod % (2**W));
            m_carry = ((prod / (2**W)) != 0);
            lat     = W;
`else
            prod    = '0;
`endif
         end
      endcase
      exp_q.push_back('{acc: m_acc, carry: m_carry, edge_n: edge_cnt + 1 + lat});
      @(negedge CLK);
      Start = 1'b0;
   endtask

   // Runs a multiply and watches the busy window; optionally injects a Start
   // that must be ignored, or pulls Reset at the given iteration.
   task automatic run_mul(input logic [W-1:0] b, input bit inject, input int abort_at);
      logic [W-1:0] old_acc;
      int busy_n = 0;
      old_acc = m_acc;
      apply_stimulus(3'd7, b);
      while (Busy && busy_n < 40) begin
         busy_n++;
         check_output("mul_hold", Acc_out, old_acc);
         if (abort_at == busy_n) begin
            Reset = 1'b0;
            exp_q.delete();
            m_acc   = '0;
            m_carry = 1'b0;
            @(negedge CLK);
            Reset = 1'b1;
            check_output("abort_acc", Acc_out, 0);
            check_output("abort_busy", Busy, 0);
            check_output("abort_done", Done, 0);
            check_output("abort_zero", Zero, 1);
            repeat (12) @(negedge CLK);
            return;
         end
         if (inject && busy_n == 3) begin
            Start = 1'b1;
            Op    = 3'b001;
            B_in  = 8'h01;
         end else begin
            Start = 1'b0;
         end
         @(negedge CLK);
      end
      Start = 1'b0;
      check_output("mul_busy_cycles", busy_n, W);
   endtask

   // Scoreboard monitor: every Done must match the oldest outstanding prediction.
   always @(negedge CLK) begin
      if (Reset && Done) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: Done=1 with no pending op (edge %0d)", edge_cnt);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("done_edge", edge_cnt, e.edge_n);
            check_output("acc", Acc_out, e.acc);
            check_output("carry", Carry, e.carry);
            check_output("zero", Zero, (e.acc == 0));
            check_output("busy_in_done", Busy, 0);
         end
      end
   end

   initial begin
      int guard;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b1;
      @(negedge CLK);
      check_output("rst_acc", Acc_out, 0);
      check_output("rst_zero", Zero, 1);
      check_output("rst_carry", Carry, 0);
      check_output("rst_busy", Busy, 0);
      check_output("rst_done", Done, 0);

      apply_stimulus(3'd0, 8'hAA);
      apply_stimulus(3'd1, 8'h56);
      apply_stimulus(3'd0, 8'h10);
      apply_stimulus(3'd2, 8'h20);
      apply_stimulus(3'd6, 8'h00);

`ifdef ACCUMULATOR_ALU_MUL_EN
      apply_stimulus(3'd0, 8'h0F);
      run_mul(8'h11, 1'b1, 0);
      apply_stimulus(3'd0, 8'hFF);
      run_mul(8'hFF, 1'b0, 0);
      apply_stimulus(3'd0, 8'h55);
      run_mul(8'h03, 1'b0, 4);
`else
      apply_stimulus(3'd0, 8'h3C);
      apply_stimulus(3'd7, 8'h5A);
`endif

      for (int i = 0; i < 40; i++) begin
         apply_stimulus(3'($urandom_range(0, 7)), W'($urandom_range(0, 255)));
      end

      guard = 0;
      while (exp_q.size() != 0 && guard < 100) begin
         @(negedge CLK);
         guard++;
      end
      repeat (3) @(negedge CLK);
      check_output("pending_ops", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
